// File: rtl/ram_responder_pkg.sv
// rtl/ram_responder_pkg.sv - shared state type, default sizing and helpers for ram_responder
package ram_responder_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ram_resp_state_t;

  localparam int RAM_RESP_ADDR_BITS = 12;
  localparam int RAM_RESP_LATENCY   = 4;

  // Smallest counter width that can hold the latency value itself.
  function automatic int ram_resp_cnt_bits(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/ram_responder_mem.sv
// rtl/ram_responder_mem.sv - single-port synchronous byte RAM with registered read data
module ram_responder_mem #(
  parameter int IDX_BITS = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                we,
  input  logic [IDX_BITS-1:0] index,
  input  logic [7:0]          wdata,
  output logic [7:0]          rdata
);

  localparam int DEPTH = 1 << IDX_BITS;

  logic [7:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[index] <= wdata;
    end
  end

  // Read register only moves on a read, so it holds the last read result.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= 8'h00;
    end else if (en && !we) begin
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - block-RAM stand-in for the PSRAM client handshake with fixed latency
// Optional read-fault injection at FAULT_ADDR when RAM_RESPONDER_FAULT_EN is defined.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int          ADDR_BITS  = RAM_RESP_ADDR_BITS,
  parameter int          LATENCY    = RAM_RESP_LATENCY,
  parameter logic [23:0] FAULT_ADDR = 24'h000010
) (
  input  logic        i_clkRAM,
  input  logic        i_reset,
  input  logic        i_cs,
  input  logic        i_write,
  input  logic [23:0] i_address,
  input  logic        i_bank,
  input  logic [7:0]  i_dataToWrite,
  output logic [7:0]  o_dataRead,
  output logic        o_busy,
  output logic        o_dataReady
);

  localparam int CNT_W = ram_resp_cnt_bits(LATENCY);
  localparam int IDX_W = ADDR_BITS + 1;

  ram_resp_state_t  state;
  logic             prev_cs;
  logic             wr_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       wdata_q;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             ready_q;
  logic [7:0]       rdata;

  logic accept;
  logic complete;
  logic mem_en;

  assign accept   = (state == IDLE) && !i_cs && prev_cs;
  assign complete = (state == WAIT) && (cnt == CNT_W'(1));
  // A reset landing on the completion edge must not commit the write.
  assign mem_en   = complete && !i_reset;

  always_ff @(posedge i_clkRAM) begin
    if (i_reset) begin
      state   <= IDLE;
      prev_cs <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 8'h00;
      cnt     <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      prev_cs <= i_cs;
      case (state)
        IDLE: begin
          if (accept) begin
            wr_q    <= i_write;
            idx_q   <= {i_bank, i_address[ADDR_BITS-1:0]};
            wdata_q <= i_dataToWrite;
            cnt     <= CNT_W'(LATENCY);
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (complete) begin
            busy_q  <= 1'b0;
            ready_q <= ready_q | !wr_q;
            state   <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ram_responder_mem #(
    .IDX_BITS (IDX_W)
  ) u_mem (
    .clk   (i_clkRAM),
    .reset (i_reset),
    .en    (mem_en),
    .we    (wr_q),
    .index (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  assign o_busy      = busy_q;
  assign o_dataReady = ready_q;

`ifdef RAM_RESPONDER_FAULT_EN
  logic fault_hit_q;
  logic fault_q;

  // Match on the full 24-bit address so aliases of FAULT_ADDR read clean.
  always_ff @(posedge i_clkRAM) begin
    if (i_reset) begin
      fault_hit_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      if (accept) begin
        fault_hit_q <= (i_address == FAULT_ADDR);
      end
      if (mem_en && !wr_q) begin
        fault_q <= fault_hit_q;
      end
    end
  end

  assign o_dataRead = rdata ^ {7'b0000000, fault_q};
`else
  localparam logic [23:0] unused_fault_addr = FAULT_ADDR;
  logic unused_upper_addr;

  assign unused_upper_addr = ^i_address[23:ADDR_BITS];
  assign o_dataRead        = rdata;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - vector table, corner sequences and random traffic against a memory model
module tb_ram_responder;

  localparam int          LAT   = 4;
  localparam int          ABITS = 12;
  localparam logic [23:0] FADDR = 24'h000010;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        wr;
  logic [23:0] addr;
  logic        bank;
  logic [7:0]  wdata;
  logic [7:0]  dout;
  logic        busy;
  logic        ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model [0:8191];

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic        bank;
    logic [7:0]  data;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [9];

  ram_responder #(
    .ADDR_BITS  (ABITS),
    .LATENCY    (LAT),
    .FAULT_ADDR (FADDR)
  ) dut (
    .i_clkRAM      (clk),
    .i_reset       (reset),
    .i_cs          (cs),
    .i_write       (wr),
    .i_address     (addr),
    .i_bank        (bank),
    .i_dataToWrite (wdata),
    .o_dataRead    (dout),
    .o_busy        (busy),
    .o_dataReady   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int midx(input logic b, input logic [23:0] a);
    return int'({b, a[ABITS-1:0]});
  endfunction

  function automatic logic [7:0] model_read(input logic b, input logic [23:0] a);
    logic [7:0] v;
    v = model[midx(b, a)];
`ifdef RAM_RESPONDER_FAULT_EN
    if (a == FADDR) v = v ^ 8'h01;
`endif
    return v;
  endfunction

  // Assumes the previous edge sampled cs high; returns number of cycles busy was seen high.
  task automatic do_req(input logic w, input logic [23:0] a, input logic b,
                        input logic [7:0] d, output int busy_n);
    wr = w; addr = a; bank = b; wdata = d; cs = 1'b0;
    tick();
    cs = 1'b1;
    busy_n = 0;
    for (int k = 0; k < 300 && busy; k++) begin
      busy_n++;
      tick();
    end
  endtask

  task automatic run_req(input logic w, input logic [23:0] a, input logic b,
                         input logic [7:0] d, input logic [7:0] exp_rd, input string tag);
    int bn;
    do_req(w, a, b, d, bn);
    chk({tag, " busy_cycles"}, bn, LAT);
    if (w) begin
      chk({tag, " ready_after_write"}, ready, 0);
      model[midx(b, a)] = d;
    end else begin
      chk({tag, " ready"}, ready, 1);
      chk({tag, " data"}, dout, exp_rd);
    end
  endtask

  initial begin
    int bn;
    int extra;

    for (int i = 0; i < 8192; i++) model[i] = 8'h00;

    vecs[0] = '{1'b1, 24'h000001, 1'b1, 8'hAA, 8'h00};
    vecs[1] = '{1'b0, 24'h000001, 1'b1, 8'h00, 8'hAA};
    vecs[2] = '{1'b1, 24'h000005, 1'b0, 8'h11, 8'h00};
    vecs[3] = '{1'b1, 24'h000005, 1'b1, 8'h22, 8'h00};
    vecs[4] = '{1'b0, 24'h000005, 1'b0, 8'h00, 8'h11};
    vecs[5] = '{1'b0, 24'h000005, 1'b1, 8'h00, 8'h22};
    vecs[6] = '{1'b0, 24'h001005, 1'b0, 8'h00, 8'h11};
    vecs[7] = '{1'b1, 24'hFFF005, 1'b1, 8'h33, 8'h00};
    vecs[8] = '{1'b0, 24'h000005, 1'b1, 8'h00, 8'h33};

    reset = 1'b1; cs = 1'b1; wr = 1'b0; addr = '0; bank = 1'b0; wdata = '0;
    repeat (3) tick();
    chk("reset busy", busy, 0);
    chk("reset ready", ready, 0);
    chk("reset data", dout, 0);

    // cs held low through reset must not start a request
    cs = 1'b0;
    tick();
    reset = 1'b0;
    bn = 0;
    repeat (6) begin
      tick();
      if (busy) bn++;
    end
    chk("cs_low_through_reset busy", bn, 0);
    cs = 1'b1;
    tick();
    run_req(1'b1, 24'h000000, 1'b0, 8'h00, 8'h00, "first_after_high");

    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].wr, vecs[i].addr, vecs[i].bank, vecs[i].data, vecs[i].exp,
              $sformatf("vec%0d", i));
    end

    // held cs: exactly one request over 20 low cycles
    wr = 1'b0; addr = 24'h000005; bank = 1'b0; cs = 1'b0;
    tick();
    bn = busy ? 1 : 0;
    repeat (20) begin
      tick();
      if (busy) bn++;
    end
    chk("held_cs busy_cycles", bn, LAT);
    chk("held_cs ready", ready, 1);
    chk("held_cs data", dout, 8'h11);
    cs = 1'b1;
    tick();

    // falling edge during WAIT is dropped
    wr = 1'b0; addr = 24'h000001; bank = 1'b1; cs = 1'b0;
    tick();
    bn = busy ? 1 : 0;
    cs = 1'b1;
    tick();
    if (busy) bn++;
    cs = 1'b0;
    tick();
    if (busy) bn++;
    cs = 1'b1;
    for (int k = 0; k < 300 && busy; k++) begin
      tick();
      if (busy) bn++;
    end
    extra = 0;
    repeat (6) begin
      tick();
      if (busy) extra++;
    end
    chk("dropped busy_cycles", bn, LAT);
    chk("dropped no_second_req", extra, 0);
    chk("dropped ready", ready, 1);
    chk("dropped data", dout, 8'hAA);

    // reset during a write aborts it
    run_req(1'b1, 24'h000009, 1'b0, 8'h33, 8'h00, "pre_reset_write");
    wr = 1'b1; addr = 24'h000009; bank = 1'b0; wdata = 8'h55; cs = 1'b0;
    tick();
    cs = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("midreset busy", busy, 0);
    chk("midreset ready", ready, 0);
    chk("midreset data", dout, 0);
    reset = 1'b0;
    tick();
    run_req(1'b0, 24'h000009, 1'b0, 8'h00, 8'h33, "post_reset_read");

    // fault injection address
    run_req(1'b1, FADDR, 1'b0, 8'hAA, 8'h00, "fault_write");
`ifdef RAM_RESPONDER_FAULT_EN
    run_req(1'b0, FADDR, 1'b0, 8'h00, 8'hAB, "fault_read");
`else
    run_req(1'b0, FADDR, 1'b0, 8'h00, 8'hAA, "fault_read");
`endif
    run_req(1'b0, 24'h001010, 1'b0, 8'h00, 8'hAA, "fault_alias_read");

    // random traffic over a small aliased footprint, pre-written so every read is defined
    for (int b = 0; b < 2; b++) begin
      for (int l = 0; l < 16; l++) begin
        run_req(1'b1, 24'(l), b[0], 8'($urandom_range(0, 255)), 8'h00, "rand_init");
      end
    end
    for (int n = 0; n < 200; n++) begin
      logic        rw;
      logic        rb;
      logic [23:0] ra;
      logic [7:0]  rd;
      rw = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      ra = {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 15))};
      rd = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) tick();
      run_req(rw, ra, rb, rd, model_read(rb, ra), $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
# ram_responder

Block-RAM-backed responder for the PSRAM controller's client-side handshake (active-low chip select, write strobe, 24-bit address, bank select, busy, data-ready). It lets RAM test sequencers and, later, the CPU/VIC bus logic run against a deterministic, on-chip memory with programmable latency. This is needed for simulation and for board bring-up before the real PSRAM path is trusted. It sits in the `gm64` top in place of the PSRAM controller.

## Interface
Parameters:
- `ADDR_BITS`, 12: implemented address bits per bank. Depth per bank is 2^ADDR_BITS bytes.
- `LATENCY`, 4: cycles from request acceptance to completion. Legal range 1..255.
- `FAULT_ADDR`, 24'h000010: address whose read data is corrupted when fault injection is compiled in.

Ports:
- `i_clkRAM`, in, 1: the block's only clock. All logic is on its rising edge.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_cs`, in, 1: chip select, active low.
- `i_write`, in, 1: 1 = write, 0 = read. Sampled at acceptance.
- `i_address`, in, 24: byte address. Only the low ADDR_BITS bits are used; upper bits are ignored and alias.
- `i_bank`, in, 1: bank select. Forms the memory index {i_bank, i_address[ADDR_BITS-1:0]}.
- `i_dataToWrite`, in, 8: write data. Sampled at acceptance.
- `o_dataRead`, out, 8: read data. Holds the last read result.
- `o_busy`, out, 1: a request is in progress.
- `o_dataReady`, out, 1: the last read has completed and `o_dataRead` is valid. Sticky.

## Operation
- States: IDLE, WAIT.
- Acceptance happens in IDLE when `i_cs` is sampled 0 and the registered previous `i_cs` is 1 (falling edge). Holding `i_cs` low never retriggers. A new request needs at least one cycle with `i_cs` high in between.
- On acceptance:
  - capture write flag, index, and data
  - load the latency counter with LATENCY
  - `o_busy` <= 1, `o_dataReady` <= 0
  - go to WAIT
- WAIT: the counter decrements every cycle. When it reaches 1:
  - write: the memory byte is updated
  - read: `o_dataRead` <= mem[index] and `o_dataReady` <= 1
  - in both cases `o_busy` <= 0 and the state returns to IDLE
- A falling edge of `i_cs` while in WAIT is dropped. It is not queued.
- The memory is not cleared by reset. Simulation initial contents are 8'h00.
- The counter width is just large enough to hold LATENCY.
- Reset mid-operation aborts the request. A pending write is discarded and the memory is unchanged.
- Reset values: `o_busy` = 0, `o_dataReady` = 0, `o_dataRead` = 8'h00, state = IDLE, previous-cs register = 0. Because of the last value, an `i_cs` held low through reset is not accepted until it has been seen high.

## Timing
- The request is accepted at edge N. `o_busy` is high from after edge N until edge N+LATENCY.
- At edge N+LATENCY, `o_busy` falls. For a read, `o_dataReady` rises in the same cycle and `o_dataRead` is valid.
- A write is visible to a read accepted at edge N+LATENCY+1 or later.
- Minimum back-to-back period: LATENCY+1 cycles, which includes the cs-high cycle. A falling edge that lands on cycle N+LATENCY+1 is accepted.
- `o_dataReady` stays high until the next acceptance. A client may sample it any number of cycles late.

## Configuration
- `RAM_RESPONDER_FAULT_EN` defined: a read whose full 24-bit `i_address` equals FAULT_ADDR returns the stored byte with bit 0 inverted. The stored byte is untouched. This exercises the failure path of RAM test sequencers.
- Not defined: no comparator is built and reads always return the stored byte.

## Structure
- Package `ram_responder_pkg`:
  - state enum typedef `ram_resp_state_t` (IDLE, WAIT)
  - default constants `RAM_RESP_ADDR_BITS` and `RAM_RESP_LATENCY`
- Sub-module `ram_responder_mem`: a single-port synchronous byte array of depth 2^(ADDR_BITS+1), with write enable, index, write data, and registered read data, so it infers block RAM. The control FSM, counter, and cs edge detector live in `ram_responder`.

## Test plan
- Write/read: write 8'hAA to address 24'h000001, bank 1, with LATENCY=4. `o_busy` is high exactly 4 cycles. A read of the same address sets `o_dataReady` 4 cycles after acceptance with `o_dataRead` = 8'hAA.
- Bank isolation and aliasing:
  - write 8'h11 to bank 0 addr 5, then 8'h22 to bank 1 addr 5: reads return 8'h11 and 8'h22 respectively
  - a read of 24'h001005 (ADDR_BITS=12) from bank 0 returns 8'h11
- Held cs: keep `i_cs` low for 20 cycles after one read. Exactly one request is performed, and `o_busy` stays low after completion.
- Dropped edge: pulse `i_cs` high→low during WAIT. The request is ignored, and after completion `o_busy` stays 0.
- Reset: assert `i_reset` at cycle 2 of a write of 8'h55 over stored 8'h33. Outputs return to 0, and a later read returns 8'h33. With `i_cs` held low through reset, no request starts.
- Fault injection: with `RAM_RESPONDER_FAULT_EN`, write 8'hAA to FAULT_ADDR and read it back. The read returns 8'hAB. Without the macro it returns 8'hAA.
